fir_parallel_banked: RTL and testbench
======================================

# fir_parallel_banked

Next-generation transposed parallel FIR for the acquisition datapath, sitting after the ADC front-end and decimators.
- Adds double-buffered coefficient banks with atomic swap, so coefficients change without glitching the running filter.
- Adds a valid-gated pipeline, so gapped and decimated streams filter correctly.
- Adds round-half-up and saturation on the output, plus a synchronous reset.

## Interface
- INT_NUMBER_OF_TAPS, 8, filter length T (≥2)
- INT_IN_DATA_WIDTH, 24, signed sample width
- INT_COEF_WIDTH, 16, signed coefficient width
- INT_OUT_DATA_WIDTH, 24, signed output width
- INT_OUT_SHIFT, 15, fractional bits dropped from the accumulator (0 allowed)
- clk  in  1  sole clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  sample strobe; gaps allowed
- i_data  in  INT_IN_DATA_WIDTH  signed sample
- i_coef_valid  in  1  write strobe into the shadow bank
- i_coef_addr  in  max(1,$clog2(T))  tap index 0..T-1
- i_coef_data  in  INT_COEF_WIDTH  signed coefficient
- i_bank_swap  in  1  single-cycle pulse: the shadow bank becomes active
- o_valid  out  1  output strobe
- o_data  out  INT_OUT_DATA_WIDTH  rounded, saturated result
- o_sat  out  1  o_data was clipped (qualified by o_valid)
- o_bank  out  1  index of the active bank
- o_settled  out  1  all taps of the current output used the active bank

## Operation
- Accumulator width ACC = IN + COEF + $clog2(T), sign-extended throughout.
- Pipeline stage S1: register i_data and valid.
- Stage S2: when S1 is valid, compute p[k] = x·c_active[k] for every tap.
- Stage S3: when S2 is valid, update acc[k] <= p[k] + acc[k+1] for k < T-1, and acc[T-1] <= p[T-1].
- Stage S4: round and saturate acc[0].
- Accumulators hold when no valid sample is present. A gap therefore never inserts zero samples.
- Rounding: r = (acc + 2^(SHIFT-1)) >>> SHIFT; the add is skipped when SHIFT = 0.
- Saturation: clip r to [-2^(OUT-1), 2^(OUT-1)-1] and set o_sat when clipping occurs.
- Coefficients are two banks of T registers. Writes always go to the bank not currently active.
- A write with i_coef_addr ≥ T is ignored.
- i_bank_swap toggles o_bank at that clock edge. Every S2 multiply from the next cycle onward uses the new bank.
- Write and swap in the same cycle: the write lands in the pre-swap shadow bank, which is the newly active one.
- A swap pulse while a swap transition is in progress restarts the transition.
- Settle counter: cleared on swap, incremented per S2 valid, saturates at T. o_settled = 1 when the count equals T at the S4 output.
- Reset: all pipeline registers and accumulators, both banks, o_data and o_bank go to 0; o_valid, o_sat and o_settled go to 0; the settle counter goes to 0.

## Timing
- Fixed latency: o_valid is high exactly 4 cycles after i_valid, independent of gaps.
- Output rate equals input valid rate. Maximum throughput is 1 sample/cycle.
- A coefficient write becomes visible only after a swap. One cycle after the swap edge it applies to S2.
- Transition: the T-1 outputs after the first new-bank product mix banks (o_settled = 0). The T-th output is pure.
- Reset asserted mid-stream: on the next edge o_valid = 0, and in-flight samples are discarded.
- The first output after reset release carries no pre-reset history.

## Structure
- Package fir_pkg holds:
  - ACC width function
  - round/saturate function
  - coefficient array typedef
- Sub-module fir_coeff_bank: the double-buffered coefficient register file with write, swap and active-bank select.
- The top level holds the S1–S4 pipeline and the settle counter.

## Test plan
- Impulse: SHIFT=0, T=8, load 1..8 and swap, then x = 1, 0×7 → o_data 1,2,…,8, each 4 cycles after its i_valid; o_sat = 0.
- Gapped input: repeat the impulse test with i_valid every third cycle → identical o_data sequence and exactly 8 o_valid pulses.
- Saturation: SHIFT=0, all c = 32767, 8 samples of x = 2^23-1 → o_data = 8388607 with o_sat = 1. With x = -2^23 → o_data = -8388608, o_sat = 1.
- Rounding: SHIFT=1, c0 = 1, others 0; x = 3 → 2; x = -3 → -1; x = 2 → 1 (o_sat = 0).
- Swap mid-stream: constant x = 1, active bank all 1, shadow bank all 2, swap → outputs 8, 9, …, 15 with o_settled = 0, then 16 with o_settled = 1; o_bank toggles at the swap edge.
- Reset mid-stream: pull i_rst_n low for 1 cycle during the stream → o_valid = 0 next cycle, o_bank = 0, banks zero; load c0 = 1, swap, impulse 5 → o_data 5, 0, … with no pre-reset residue.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the banked parallel FIR.
package fir_pkg;

  localparam int DEF_TAPS   = 8;
  localparam int DEF_COEF_W = 16;

  typedef logic signed [DEF_COEF_W-1:0] coefArray_t [DEF_TAPS];

  typedef struct packed {
    logic [63:0] value;
    logic        sat;
  } roundSat_t;

  function automatic int accWidth(input int taps, input int inW, input int coefW);
    return inW + coefW + $clog2(taps);
  endfunction

  // Round half up, then clip into the signed outW-bit range.
  function automatic roundSat_t roundSat(input logic signed [63:0] acc, input int shift,
                                         input int outW);
    roundSat_t          res;
    logic signed [63:0] r;
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    r = acc;
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    maxV      = (64'sd1 <<< (outW - 1)) - 64'sd1;
    minV      = -(64'sd1 <<< (outW - 1));
    res.value = r;
    res.sat   = 1'b0;
    if (r > maxV) begin
      res.value = maxV;
      res.sat   = 1'b1;
    end else if (r < minV) begin
      res.value = minV;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_parallel_banked_if.sv
// Sample, coefficient-write and result signals of the banked FIR.
interface fir_parallel_banked_if
  import fir_pkg::*;
#(
  parameter int INT_NUMBER_OF_TAPS = 8,
  parameter int INT_IN_DATA_WIDTH  = 24,
  parameter int INT_COEF_WIDTH     = 16,
  parameter int INT_OUT_DATA_WIDTH = 24
);

  localparam int ADDR_W = (INT_NUMBER_OF_TAPS > 1) ? $clog2(INT_NUMBER_OF_TAPS) : 1;

  logic                                 i_valid;
  logic signed [INT_IN_DATA_WIDTH-1:0]  i_data;
  logic                                 i_coef_valid;
  logic [ADDR_W-1:0]                    i_coef_addr;
  logic signed [INT_COEF_WIDTH-1:0]     i_coef_data;
  logic                                 i_bank_swap;
  logic                                 o_valid;
  logic signed [INT_OUT_DATA_WIDTH-1:0] o_data;
  logic                                 o_sat;
  logic                                 o_bank;
  logic                                 o_settled;

  modport master (
    output i_valid, i_data, i_coef_valid, i_coef_addr, i_coef_data, i_bank_swap,
    input  o_valid, o_data, o_sat, o_bank, o_settled
  );

  modport slave (
    input  i_valid, i_data, i_coef_valid, i_coef_addr, i_coef_data, i_bank_swap,
    output o_valid, o_data, o_sat, o_bank, o_settled
  );

endinterface

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient register file: writes fill the shadow bank,
// a swap pulse makes it active in one edge.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int INT_NUMBER_OF_TAPS = 8,
  parameter int INT_COEF_WIDTH     = 16,
  parameter int ADDR_W             = 3
) (
  input  logic                             clk,
  input  logic                             i_rst_n,
  input  logic                             i_coef_valid,
  input  logic [ADDR_W-1:0]                i_coef_addr,
  input  logic signed [INT_COEF_WIDTH-1:0] i_coef_data,
  input  logic                             i_bank_swap,
  output logic                             o_bank,
  output logic signed [INT_COEF_WIDTH-1:0] o_coef [INT_NUMBER_OF_TAPS]
);

  logic signed [INT_COEF_WIDTH-1:0] bank_q [2][INT_NUMBER_OF_TAPS];
  logic                             active_q;
  logic                             addrOk;

  assign addrOk = (32'(i_coef_addr) < INT_NUMBER_OF_TAPS);

  // A write coinciding with a swap targets the pre-swap shadow, i.e. the newly active bank.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < INT_NUMBER_OF_TAPS; k++) begin
          bank_q[b][k] <= '0;
        end
      end
      active_q <= 1'b0;
    end else begin
      if (i_coef_valid && addrOk) bank_q[~active_q][i_coef_addr] <= i_coef_data;
      if (i_bank_swap) active_q <= ~active_q;
    end
  end

  always_comb begin
    for (int k = 0; k < INT_NUMBER_OF_TAPS; k++) begin
      o_coef[k] = bank_q[active_q][k];
    end
  end

  assign o_bank = active_q;

endmodule

// File: rtl/fir_parallel_banked.sv
// Transposed parallel FIR with valid-gated S1..S4 pipeline, banked coefficients,
// round-half-up/saturating output and a bank-settle indicator.
module fir_parallel_banked
  import fir_pkg::*;
#(
  parameter int INT_NUMBER_OF_TAPS = 8,
  parameter int INT_IN_DATA_WIDTH  = 24,
  parameter int INT_COEF_WIDTH     = 16,
  parameter int INT_OUT_DATA_WIDTH = 24,
  parameter int INT_OUT_SHIFT      = 15
) (
  input logic                  clk,
  input logic                  i_rst_n,
  fir_parallel_banked_if.slave bus
);

  localparam int T      = INT_NUMBER_OF_TAPS;
  localparam int ACC    = accWidth(T, INT_IN_DATA_WIDTH, INT_COEF_WIDTH);
  localparam int CW     = $clog2(T + 1);
  localparam int ADDR_W = (T > 1) ? $clog2(T) : 1;

  logic signed [INT_COEF_WIDTH-1:0]     coefActive [T];
  logic signed [INT_IN_DATA_WIDTH-1:0]  x_q;
  logic                                 v1_q, v2_q, v3_q;
  logic signed [ACC-1:0]                p_d [T];
  logic signed [ACC-1:0]                p_q [T];
  logic signed [ACC-1:0]                acc_q [T];
  logic                                 set2_q, set3_q;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic                                 o_valid_q, o_sat_q, o_settled_q;
  logic signed [INT_OUT_DATA_WIDTH-1:0] o_data_q;
  roundSat_t                            rs;
  logic                                 unused_rs;

  fir_coeff_bank #(
    .INT_NUMBER_OF_TAPS(T),
    .INT_COEF_WIDTH    (INT_COEF_WIDTH),
    .ADDR_W            (ADDR_W)
  ) u_bank (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_coef_valid(bus.i_coef_valid),
    .i_coef_addr (bus.i_coef_addr),
    .i_coef_data (bus.i_coef_data),
    .i_bank_swap (bus.i_bank_swap),
    .o_bank      (bus.o_bank),
    .o_coef      (coefActive)
  );

  // Swap clears the count even when an S2 product happens on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_bank_swap) cnt_d = '0;
    else if (v1_q && (cnt_q != CW'(T))) cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    for (int k = 0; k < T; k++) begin
      p_d[k] = ACC'(x_q) * ACC'(coefActive[k]);
    end
  end

  always_comb begin
    rs = roundSat({{(64 - ACC){acc_q[0][ACC-1]}}, acc_q[0]}, INT_OUT_SHIFT, INT_OUT_DATA_WIDTH);
  end

  assign unused_rs = ^rs.value[63:INT_OUT_DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      x_q         <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      set2_q      <= 1'b0;
      set3_q      <= 1'b0;
      cnt_q       <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_sat_q     <= 1'b0;
      o_settled_q <= 1'b0;
      for (int k = 0; k < T; k++) begin
        p_q[k]   <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      v1_q  <= bus.i_valid;
      if (bus.i_valid) x_q <= bus.i_data;
      cnt_q <= cnt_d;
      v2_q  <= v1_q;
      if (v1_q) begin
        for (int k = 0; k < T; k++) begin
          p_q[k] <= p_d[k];
        end
        set2_q <= (cnt_d == CW'(T));
      end
      v3_q <= v2_q;
      // Accumulators only move on a valid product, so gaps never inject zeros.
      if (v2_q) begin
        for (int k = 0; k < T - 1; k++) begin
          acc_q[k] <= p_q[k] + acc_q[k+1];
        end
        acc_q[T-1] <= p_q[T-1];
        set3_q     <= set2_q;
      end
      o_valid_q <= v3_q;
      if (v3_q) begin
        o_data_q    <= rs.value[INT_OUT_DATA_WIDTH-1:0];
        o_sat_q     <= rs.sat;
        o_settled_q <= set3_q;
      end
    end
  end

  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = o_data_q;
  assign bus.o_sat     = o_sat_q;
  assign bus.o_settled = o_settled_q;

endmodule

// File: tb/tb_fir_parallel_banked.sv
// Self-checking bench: three DUTs (shift 0, 1, 15) share stimulus and are
// compared every cycle against a convolution model with per-sample bank snapshots.
module tb_fir_parallel_banked;
  import fir_pkg::*;

  localparam int T      = 8;
  localparam int IN_W   = 24;
  localparam int COEF_W = 16;
  localparam int OUT_W  = 24;
  localparam longint MAXO = 64'sd8388607;
  localparam longint MINO = -64'sd8388608;

  logic                     clk = 1'b0;
  logic                     rstN;
  logic                     valid;
  logic signed [IN_W-1:0]   data;
  logic                     coefValid;
  logic [2:0]               coefAddr;
  logic signed [COEF_W-1:0] coefData;
  logic                     bankSwap;

  logic                    oValid [3];
  logic                    oSat [3];
  logic                    oBank [3];
  logic                    oSettled [3];
  logic signed [OUT_W-1:0] oData [3];

  always #5 clk = ~clk;

  fir_parallel_banked_if #(
    .INT_NUMBER_OF_TAPS(T), .INT_IN_DATA_WIDTH(IN_W),
    .INT_COEF_WIDTH(COEF_W), .INT_OUT_DATA_WIDTH(OUT_W)
  ) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : gDut
    assign bus[g].i_valid      = valid;
    assign bus[g].i_data       = data;
    assign bus[g].i_coef_valid = coefValid;
    assign bus[g].i_coef_addr  = coefAddr;
    assign bus[g].i_coef_data  = coefData;
    assign bus[g].i_bank_swap  = bankSwap;
    assign oValid[g]   = bus[g].o_valid;
    assign oData[g]    = bus[g].o_data;
    assign oSat[g]     = bus[g].o_sat;
    assign oBank[g]    = bus[g].o_bank;
    assign oSettled[g] = bus[g].o_settled;

    fir_parallel_banked #(
      .INT_NUMBER_OF_TAPS(T), .INT_IN_DATA_WIDTH(IN_W), .INT_COEF_WIDTH(COEF_W),
      .INT_OUT_DATA_WIDTH(OUT_W), .INT_OUT_SHIFT((g == 0) ? 0 : (g == 1) ? 1 : 15)
    ) dut (
      .clk    (clk),
      .i_rst_n(rstN),
      .bus    (bus[g])
    );
  end

  typedef struct {
    int     due;
    longint y;
    bit     settled;
  } exp_t;

  longint bankM [2][T];
  bit     activeM;
  int     cntM;
  bit     pendV;
  longint pendX;
  longint histX [T];
  longint histC [T][T];
  exp_t   expQ [$];
  int     cyc;
  int     total;
  int     bad;
  longint q0data [$];
  bit     q0sat [$];
  bit     q0set [$];
  longint q1data [$];

  function automatic int shiftOf(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : 15;
  endfunction

  function automatic longint rounded(input longint y, input int s);
    if (s == 0) return y;
    return (y + (longint'(1) <<< (s - 1))) >>> s;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Spec-level model: y[n] = sum_k x[n-k] * c_used_by(n-k)[k]; reset empties history.
  task automatic modelEdge();
    cyc++;
    if (!rstN) begin
      for (int k = 0; k < T; k++) begin
        bankM[0][k] = 0;
        bankM[1][k] = 0;
        histX[k]    = 0;
        for (int j = 0; j < T; j++) histC[k][j] = 0;
      end
      activeM = 0;
      cntM    = 0;
      pendV   = 0;
      expQ.delete();
    end else begin
      if (bankSwap) cntM = 0;
      else if (pendV && cntM < T) cntM++;
      if (pendV) begin
        longint y;
        for (int k = T - 1; k > 0; k--) begin
          histX[k] = histX[k-1];
          histC[k] = histC[k-1];
        end
        histX[0] = pendX;
        for (int k = 0; k < T; k++) histC[0][k] = bankM[activeM][k];
        y = 0;
        for (int k = 0; k < T; k++) y += histX[k] * histC[k][k];
        expQ.push_back('{cyc + 2, y, (cntM == T)});
      end
      if (coefValid && int'(coefAddr) < T) bankM[!activeM][coefAddr] = longint'(coefData);
      if (bankSwap) activeM = ~activeM;
      pendV = valid;
      pendX = longint'(data);
    end
  endtask

  task automatic step();
    exp_t e;
    bit   expV;
    @(posedge clk);
    modelEdge();
    #1;
    expV = 0;
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      e    = expQ.pop_front();
      expV = 1;
    end
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("valid%0d", g), oValid[g], expV);
      checkOutput($sformatf("bank%0d", g), oBank[g], activeM);
      if (expV) begin
        longint r = rounded(e.y, shiftOf(g));
        bit     s = 0;
        if (r > MAXO) begin
          r = MAXO;
          s = 1;
        end else if (r < MINO) begin
          r = MINO;
          s = 1;
        end
        checkOutput($sformatf("data%0d", g), oData[g], r);
        checkOutput($sformatf("sat%0d", g), oSat[g], s);
        checkOutput($sformatf("settled%0d", g), oSettled[g], e.settled);
      end
    end
    if (oValid[0]) begin
      q0data.push_back(longint'(oData[0]));
      q0sat.push_back(oSat[0]);
      q0set.push_back(oSettled[0]);
    end
    if (oValid[1]) q1data.push_back(longint'(oData[1]));
  endtask

  task automatic applyStimulus(input bit r, input bit v, input longint d, input bit cv,
                               input int ca, input longint cd, input bit sw);
    rstN      = r;
    valid     = v;
    data      = IN_W'(d);
    coefValid = cv;
    coefAddr  = 3'(ca);
    coefData  = COEF_W'(cd);
    bankSwap  = sw;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    idle(1);
  endtask

  task automatic loadCoefs(input int mode, input longint val, input bit swapAfter);
    for (int k = 0; k < T; k++) begin
      longint c = (mode == 0) ? longint'(k + 1) : (mode == 1) ? val : ((k == 0) ? val : 0);
      applyStimulus(1, 0, 0, 1, k, c, 0);
    end
    if (swapAfter) applyStimulus(1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic clearCapture();
    q0data.delete();
    q0sat.delete();
    q0set.delete();
    q1data.delete();
  endtask

  initial begin
    int idx;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rstN = 0; valid = 0; data = '0; coefValid = 0; coefAddr = '0; coefData = '0; bankSwap = 0;
    doReset();
    checkOutput("resetValid", oValid[0], 0);
    checkOutput("resetBank", oBank[0], 0);
    checkOutput("resetData", oData[0], 0);

    $display("[TB] impulse");
    loadCoefs(0, 0, 1);
    clearCapture();
    for (int k = 0; k < T; k++) applyStimulus(1, 1, (k == 0) ? 1 : 0, 0, 0, 0, 0);
    idle(6);
    checkOutput("impCount", q0data.size(), 8);
    for (int k = 0; k < q0data.size() && k < 8; k++) begin
      checkOutput("impData", q0data[k], k + 1);
      checkOutput("impSat", q0sat[k], 0);
    end

    $display("[TB] gapped impulse");
    clearCapture();
    for (int k = 0; k < T; k++) begin
      applyStimulus(1, 1, (k == 0) ? 1 : 0, 0, 0, 0, 0);
      idle(2);
    end
    idle(6);
    checkOutput("gapCount", q0data.size(), 8);
    for (int k = 0; k < q0data.size() && k < 8; k++) checkOutput("gapData", q0data[k], k + 1);

    $display("[TB] saturation");
    doReset();
    loadCoefs(1, 32767, 1);
    clearCapture();
    repeat (T) applyStimulus(1, 1, 8388607, 0, 0, 0, 0);
    idle(6);
    checkOutput("satPosCount", q0data.size(), 8);
    if (q0data.size() > 0) begin
      checkOutput("satPosData", q0data[q0data.size()-1], 8388607);
      checkOutput("satPosFlag", q0sat[q0sat.size()-1], 1);
    end
    clearCapture();
    repeat (T) applyStimulus(1, 1, -8388608, 0, 0, 0, 0);
    idle(6);
    if (q0data.size() > 0) begin
      checkOutput("satNegData", q0data[q0data.size()-1], -8388608);
      checkOutput("satNegFlag", q0sat[q0sat.size()-1], 1);
    end

    $display("[TB] rounding");
    doReset();
    loadCoefs(2, 1, 1);
    clearCapture();
    applyStimulus(1, 1, 3, 0, 0, 0, 0);
    applyStimulus(1, 1, -3, 0, 0, 0, 0);
    applyStimulus(1, 1, 2, 0, 0, 0, 0);
    idle(6);
    checkOutput("rndCount", q1data.size(), 3);
    if (q1data.size() == 3) begin
      checkOutput("rnd3", q1data[0], 2);
      checkOutput("rndM3", q1data[1], -1);
      checkOutput("rnd2", q1data[2], 1);
    end

    $display("[TB] swap mid-stream");
    doReset();
    loadCoefs(1, 1, 1);
    loadCoefs(1, 2, 0);
    clearCapture();
    repeat (12) applyStimulus(1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 1);
    checkOutput("swapBank", oBank[0], 0);
    repeat (12) applyStimulus(1, 1, 1, 0, 0, 0, 0);
    idle(6);
    idx = -1;
    for (int k = 0; k < q0data.size(); k++) begin
      if (idx < 0 && q0data[k] == 9) idx = k;
    end
    checkOutput("swapFound", (idx >= 1 && idx + 8 <= q0data.size()), 1);
    if (idx >= 1 && idx + 8 <= q0data.size()) begin
      checkOutput("swapOld", q0data[idx-1], 8);
      checkOutput("swapOldSet", q0set[idx-1], 0);
      for (int j = 0; j < 8; j++) begin
        checkOutput("swapRamp", q0data[idx+j], 9 + j);
        checkOutput("swapSet", q0set[idx+j], (j == 7) ? 1 : 0);
      end
    end

    $display("[TB] reset mid-stream");
    repeat (5) applyStimulus(1, 1, $urandom_range(0, 1000), 0, 0, 0, 0);
    applyStimulus(0, 1, 77, 0, 0, 0, 0);
    checkOutput("rstMidValid", oValid[0], 0);
    checkOutput("rstMidBank", oBank[0], 0);
    loadCoefs(2, 1, 1);
    clearCapture();
    for (int k = 0; k < T; k++) applyStimulus(1, 1, (k == 0) ? 5 : 0, 0, 0, 0, 0);
    idle(6);
    checkOutput("rstMidCount", q0data.size(), 8);
    for (int k = 0; k < q0data.size() && k < 8; k++)
      checkOutput("rstMidData", q0data[k], (k == 0) ? 5 : 0);

    $display("[TB] random");
    doReset();
    repeat (3000) begin
      applyStimulus($urandom_range(0, 249) != 0, $urandom_range(0, 1) == 1,
                    longint'($urandom_range(0, 16777215)) - 8388608,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 7),
                    longint'($urandom_range(0, 65535)) - 32768,
                    $urandom_range(0, 29) == 0);
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
